// File: rtl/text_buf_writer_if.sv
// Command stream into the text buffer writer: valid/ready with a 2-bit
// command and a glyph code that only PUT uses.
interface text_buf_writer_if #(
    parameter int CODE_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_cmd;
    logic [CODE_W-1:0] in_code;

    modport master (output in_valid, in_cmd, in_code, input in_ready);
    modport slave  (input in_valid, in_cmd, in_code, output in_ready);
endinterface

// File: rtl/text_buf_writer.sv
// Write side of the text path: cursor tracking, command decode and a COLS x ROWS
// cell buffer of {lit, code} with a registered read port for the glyph renderer.
module text_buf_writer #(
    parameter int  COLS   = 10,
    parameter int  ROWS   = 4,
    parameter int  CODE_W = 3,
    localparam int CW     = $clog2(COLS),
    localparam int RW     = $clog2(ROWS)
) (
    input  logic              clk_pix,
    input  logic              rst_n,
    text_buf_writer_if.slave  bus,
    output logic              busy,
    output logic [CW-1:0]     cursor_col,
    output logic [RW-1:0]     cursor_row,
    input  logic [CW-1:0]     rd_col,
    input  logic [RW-1:0]     rd_row,
    output logic [CODE_W-1:0] rd_code,
    output logic              rd_lit
);
    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);

    typedef enum logic {SWEEP, IDLE} state_e;
    typedef enum logic [1:0] {CMD_PUT, CMD_NL, CMD_CLR, CMD_HOME} cmd_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CODE_W:0] rd_q, rd_d;

    // No reset on the array: the sweep after every reset release clears it.
    logic [CODE_W:0] mem [N];

    logic            we;
    logic [IW-1:0]   waddr;
    logic [CODE_W:0] wdata;
    logic [IW-1:0]   cur_idx, rd_idx;
    logic            rd_ok;

    function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
        return (int'(r) == ROWS - 1) ? '0 : r + RW'(1);
    endfunction

    assign cur_idx = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign rd_idx  = IW'(rd_row) * IW'(COLS) + IW'(rd_col);
    assign rd_ok   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        we      = 1'b0;
        waddr   = cur_idx;
        wdata   = '0;
        case (state_q)
            SWEEP: begin
                we    = 1'b1;
                waddr = idx_q;
                if (int'(idx_q) == N - 1) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            IDLE: begin
                if (bus.in_valid) begin
                    case (cmd_e'(bus.in_cmd))
                        CMD_PUT: begin
                            we    = 1'b1;
                            wdata = {1'b1, bus.in_code};
                            if (int'(col_q) == COLS - 1) begin
                                col_d = '0;
                                row_d = row_inc(row_q);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                        CMD_NL: begin
                            col_d = '0;
                            row_d = row_inc(row_q);
                        end
                        // The accepting cycle writes nothing; the sweep starts next edge.
                        CMD_CLR: begin
                            col_d   = '0;
                            row_d   = '0;
                            idx_d   = '0;
                            state_d = SWEEP;
                        end
                        CMD_HOME: begin
                            col_d = '0;
                            row_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // Sampled before this edge's write lands, so a same-cell read sees old data.
    always_comb begin
        rd_d = '0;
        if (rd_ok) rd_d = mem[rd_idx];
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (we) mem[waddr] <= wdata;
    end

    assign busy         = (state_q == SWEEP);
    assign bus.in_ready = (state_q == IDLE);
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;
    assign rd_code      = rd_q[CODE_W-1:0];
    assign rd_lit       = rd_q[CODE_W];
endmodule

// File: tb/tb_text_buf_writer.sv
// Directed bench for text_buf_writer: sweep timing, PUT/NEWLINE/HOME/CLEAR,
// cursor wrap, mid-sweep reset and read-before-write on the read port.
module tb_text_buf_writer;
    localparam int COLS   = 10;
    localparam int ROWS   = 4;
    localparam int CODE_W = 3;
    localparam logic [1:0] PUT = 2'd0, NL = 2'd1, CLR = 2'd2, HOME = 2'd3;

    logic              clk_pix = 1'b0;
    logic              rst_n   = 1'b0;
    logic              busy;
    logic [3:0]        cursor_col;
    logic [1:0]        cursor_row;
    logic [3:0]        rd_col  = '0;
    logic [1:0]        rd_row  = '0;
    logic [CODE_W-1:0] rd_code;
    logic              rd_lit;

    int n_chk    = 0;
    int n_err    = 0;
    int busy_bad = 0;
    int cnt;
    int nlit;
    int t2[10] = '{0, 1, 2, 3, 3, 3, 4, 5, 1, 4};

    text_buf_writer_if #(.CODE_W(CODE_W)) bus ();

    text_buf_writer #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W)) dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_code    (rd_code),
        .rd_lit     (rd_lit)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [2:0] code);
        bus.in_valid = 1'b1;
        bus.in_cmd   = c;
        bus.in_code  = code;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input int c, input int r);
        rd_col = c[3:0];
        rd_row = r[1:0];
        tick();
    endtask

    task automatic chk_cur(input string tag, input int c, input int r);
        chk({tag, ".col"}, int'(cursor_col), c);
        chk({tag, ".row"}, int'(cursor_row), r);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            if (!busy) busy_bad++;
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_cmd   = '0;
        bus.in_code  = '0;
        repeat (3) tick();

        // 1: reset state, sweep length, blank buffer
        chk("rst.busy", int'(busy), 1);
        chk("rst.ready", int'(bus.in_ready), 0);
        chk("rst.rd_code", int'(rd_code), 0);
        chk("rst.rd_lit", int'(rd_lit), 0);
        chk_cur("rst.cur", 0, 0);
        rst_n = 1'b1;
        wait_ready(cnt);
        chk("t1.sweep_len", cnt, 40);
        chk("t1.busy_idle", int'(busy), 0);
        nlit = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd(c, r);
                if (rd_lit) nlit++;
            end
        chk("t1.lit_cells", nlit, 0);

        // 2: a full row of PUTs wraps the cursor to the next row
        foreach (t2[i]) send(PUT, 3'(t2[i]));
        chk_cur("t2.cur", 0, 1);
        rd(3, 0);
        chk("t2.rd30.code", int'(rd_code), 3);
        chk("t2.rd30.lit", int'(rd_lit), 1);
        rd(9, 0);
        chk("t2.rd90.code", int'(rd_code), 4);
        chk("t2.rd90.lit", int'(rd_lit), 1);
        rd_col = 4'd7;
        #1;
        chk("t2.latency_hold", int'(rd_code), 4);
        tick();
        chk("t2.latency_new", int'(rd_code), 5);

        // 3: NEWLINE mid-row, HOME, row wrap on NEWLINE and on PUT
        send(PUT, 3'd7);
        send(NL, 3'd5);
        chk_cur("t3.nl", 0, 2);
        send(HOME, 3'd6);
        chk_cur("t3.home", 0, 0);
        repeat (11) send(NL, 3'd0);
        chk_cur("t3.nl11", 0, 3);
        repeat (9) send(PUT, 3'd1);
        chk_cur("t3.put9", 9, 3);
        send(PUT, 3'd5);
        chk_cur("t3.wrap", 0, 0);
        rd(9, 3);
        chk("t3.rd93.code", int'(rd_code), 5);
        chk("t3.rd93.lit", int'(rd_lit), 1);
        rd(8, 3);
        chk("t3.rd83.code", int'(rd_code), 1);
        rd(0, 1);
        chk("t3.rd01.code", int'(rd_code), 7);

        // 4: CLEAR with a PUT waiting behind it
        bus.in_valid = 1'b1;
        bus.in_cmd   = CLR;
        bus.in_code  = 3'd7;
        tick();
        bus.in_cmd  = PUT;
        bus.in_code = 3'd2;
        chk("t4.busy", int'(busy), 1);
        chk_cur("t4.cur", 0, 0);
        wait_ready(cnt);
        chk("t4.sweep_len", cnt, 40);
        tick();
        bus.in_valid = 1'b0;
        chk_cur("t4.after_put", 1, 0);
        rd(0, 0);
        chk("t4.rd00.code", int'(rd_code), 2);
        chk("t4.rd00.lit", int'(rd_lit), 1);
        rd(9, 3);
        chk("t4.rd93.lit", int'(rd_lit), 0);

        // 5: reset in the middle of a sweep
        send(NL, 3'd0);
        send(NL, 3'd0);
        send(PUT, 3'd3);
        chk_cur("t5.cur", 1, 2);
        rd_col = 4'd0;
        rd_row = 2'd2;
        send(CLR, 3'd0);
        repeat (17) tick();
        chk("t5.partial.lit", int'(rd_lit), 1);
        chk("t5.partial.code", int'(rd_code), 3);
        rst_n = 1'b0;
        #1;
        chk("t5.rst.lit", int'(rd_lit), 0);
        chk("t5.rst.code", int'(rd_code), 0);
        chk("t5.rst.busy", int'(busy), 1);
        chk("t5.rst.ready", int'(bus.in_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ready(cnt);
        chk("t5.sweep_len", cnt, 40);
        chk_cur("t5.cur_after", 0, 0);
        rd(0, 2);
        chk("t5.rd02.lit", int'(rd_lit), 0);

        // 6: read-before-write on the same cell, out-of-range column
        send(NL, 3'd0);
        repeat (3) send(PUT, 3'd1);
        send(HOME, 3'd0);
        send(NL, 3'd0);
        send(PUT, 3'd0);
        send(PUT, 3'd0);
        chk_cur("t6.cur", 2, 1);
        rd_col       = 4'd2;
        rd_row       = 2'd1;
        bus.in_valid = 1'b1;
        bus.in_cmd   = PUT;
        bus.in_code  = 3'd6;
        tick();
        bus.in_valid = 1'b0;
        chk("t6.rbw_old.code", int'(rd_code), 1);
        chk("t6.rbw_old.lit", int'(rd_lit), 1);
        tick();
        chk("t6.rbw_new.code", int'(rd_code), 6);
        chk("t6.rbw_new.lit", int'(rd_lit), 1);
        rd(12, 0);
        chk("t6.oob.lit", int'(rd_lit), 0);
        chk("t6.oob.code", int'(rd_code), 0);
        chk_cur("t6.cur_end", 3, 1);

        chk("sweep_busy", busy_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
